// File: rtl/shift_rx_pkg.sv
// Shared definitions for the serial receive controller: the receiver state
// encoding and the default frame width.
package shift_rx_pkg;

    // Number of data bits per frame when the parent does not override WIDTH.
    localparam int DEFAULT_WIDTH = 4;

    // Receiver frame states. PARITY is only reachable when the parity option
    // is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

endpackage : shift_rx_pkg

// File: rtl/sipo_shift.sv
// Serial-in / parallel-out shift datapath. Each enabled cycle shifts right by
// one place with the new bit entering the MSB, so an LSB-first serial stream
// ends up in natural bit order after WIDTH shifts.
module sipo_shift
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Shift register: synchronous clear, right shift on en.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is always written with non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule : sipo_shift

// File: rtl/shift_rx_ctrl.sv
// Serial frame receiver: start bit (0), WIDTH data bits LSB first, optional
// even-parity bit, stop bit (1). Bits are sampled only on sen strobes.
// Completed words are presented on a valid/ready output port with a single
// holding register; a word that completes while the holding register is full
// and not being drained is dropped and flagged with an overrun pulse.
//
// Build option: define SHIFT_RX_PARITY_EN to add the parity bit and the
// parity_err check. Without it parity_err is held at 0.
module shift_rx_ctrl
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sen,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    // Counter wide enough to hold the value WIDTH.
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             shift_en;
    logic [WIDTH-1:0] shift_q;

    // One-cycle strobes produced by the stop sample.
    logic             stop_ok;
    logic             stop_bad;

`ifdef SHIFT_RX_PARITY_EN
    // Remembers a parity mismatch from the PARITY sample until STOP.
    logic             par_bad;
    logic             par_bad_next;
    logic             par_fail;
`endif

    sipo_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .sin (sin),
        .q   (shift_q)
    );

    // State, bit counter and parity flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
`ifdef SHIFT_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
`ifdef SHIFT_RX_PARITY_EN
            par_bad <= par_bad_next;
`endif
        end
    end

    // Next-state logic: every transition and every datapath step is gated by
    // sen, so non-strobe cycles hold the whole frame context.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_next   = state;
        cnt_next     = cnt;
        shift_en     = 1'b0;
        stop_ok      = 1'b0;
        stop_bad     = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
        par_bad_next = par_bad;
        par_fail     = 1'b0;
`endif

        unique case (state)
            IDLE: begin
                // Only a low sample is a start bit; idle-high samples are ignored.
                if (sen && !sin) begin
                    state_next   = DATA;
                    cnt_next     = '0;
`ifdef SHIFT_RX_PARITY_EN
                    par_bad_next = 1'b0;
`endif
                end
            end

            DATA: begin
                if (sen) begin
                    shift_en = 1'b1;
                    cnt_next = cnt + CW'(1);
                    if (cnt == LAST) begin
`ifdef SHIFT_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end

            PARITY: begin
`ifdef SHIFT_RX_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to 0.
                if (sen) begin
                    par_bad_next = ^{shift_q, sin};
                    state_next   = STOP;
                end
`else
                state_next = IDLE;
`endif
            end

            STOP: begin
                if (sen) begin
                    state_next = IDLE;
                    if (!sin) begin
                        stop_bad = 1'b1;
`ifdef SHIFT_RX_PARITY_EN
                    end else if (!par_bad) begin
`else
                    end else begin
`endif
                        stop_ok = 1'b1;
                    end
`ifdef SHIFT_RX_PARITY_EN
                    par_fail = par_bad;
`endif
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Output holding register, valid/ready handshake and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (stop_ok) begin
                // A word may load when the register is empty or drains this cycle.
                if (!dout_valid || dout_ready) begin
                    dout       <= shift_q;
                    dout_valid <= 1'b1;
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_RX_PARITY_EN
    // Parity error pulse, issued alongside the stop-sample outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_fail;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule : shift_rx_ctrl

// File: tb/tb_shift_rx_ctrl.sv
// Self-checking bench for shift_rx_ctrl. A frame-level reference model
// collects strobed bits in a queue, decodes complete frames arithmetically
// and predicts the output port every cycle; directed frames pin the model
// with literal expectations, then randomized frames, gaps, junk and resets
// exercise the rest. Works with and without SHIFT_RX_PARITY_EN.
module tb_shift_rx_ctrl;

    localparam int W = 4;
`ifdef SHIFT_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_LEN = 1 + W + PBITS + 1;

    logic         clk;
    logic         rst;
    logic         sen;
    logic         sin;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;

    int checks   = 0;
    int failures = 0;

    shift_rx_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sen        (sen),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit           bits[$];
    logic [W-1:0] exp_dout;
    logic         exp_valid;
    logic         exp_busy;
    logic         exp_ferr;
    logic         exp_perr;
    logic         exp_ovr;
    logic         model_live = 1'b0;
    logic [W-1:0] m_word;
    logic         m_par_ok;
    logic         m_done;

    initial begin : model
        forever begin
            @(posedge clk);
            if (rst) begin
                bits.delete();
                exp_dout   = '0;
                exp_valid  = 1'b0;
                exp_ferr   = 1'b0;
                exp_perr   = 1'b0;
                exp_ovr    = 1'b0;
                model_live = 1'b1;
            end else begin
                exp_ferr = 1'b0;
                exp_perr = 1'b0;
                exp_ovr  = 1'b0;
                m_done   = 1'b0;
                // Idle-high strobes before a start bit are not part of a frame.
                if (sen && !(bits.size() == 0 && sin)) begin
                    bits.push_back(sin);
                    if (bits.size() == FRAME_LEN) begin
                        for (int i = 0; i < W; i++) m_word[i] = bits[1 + i];
                        m_par_ok = 1'b1;
`ifdef SHIFT_RX_PARITY_EN
                        m_par_ok = (((^m_word) ^ bits[W + 1]) == 1'b0);
`endif
                        exp_ferr = !bits[FRAME_LEN - 1];
                        exp_perr = !m_par_ok;
                        m_done   = bits[FRAME_LEN - 1] && m_par_ok;
                        bits.delete();
                    end
                end
                if (m_done) begin
                    if (exp_valid && !dout_ready) begin
                        exp_ovr = 1'b1;
                    end else begin
                        exp_dout  = m_word;
                        exp_valid = 1'b1;
                    end
                end else if (exp_valid && dout_ready) begin
                    exp_valid = 1'b0;
                end
            end
            exp_busy = (bits.size() != 0);
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("dout",       32'(dout),       32'(exp_dout));
            check("dout_valid", 32'(dout_valid), 32'(exp_valid));
            check("busy",       32'(busy),       32'(exp_busy));
            check("frame_err",  32'(frame_err),  32'(exp_ferr));
            check("parity_err", 32'(parity_err), 32'(exp_perr));
            check("overrun",    32'(overrun),    32'(exp_ovr));
        end
    end

    // ---------------- stimulus helpers ----------------
    // One clock: inputs applied just after an edge, sampled at the next edge.
    task automatic step(input logic s, input logic b, input logic rdy);
        sen        = s;
        sin        = b;
        dout_ready = rdy;
        @(posedge clk);
        #1;
        sen = 1'b0;
        sin = 1'b1;
    endtask

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Sends start, data (LSB first), optional parity, stop. dout_ready is 0 on
    // every cycle except the stop sample (ready_last) unless rand_rdy is set.
    task automatic send_frame(input logic [W-1:0] data, input logic bad_par,
                              input logic stop_bit, input logic ready_last,
                              input logic gaps, input logic rand_rdy);
        logic fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < W; i++) fb.push_back(data[i]);
`ifdef SHIFT_RX_PARITY_EN
        fb.push_back((^data) ^ bad_par);
`else
        if (bad_par) begin
            // No parity bit exists in this build; the flag has no effect.
        end
`endif
        fb.push_back(stop_bit);
        for (int k = 0; k < fb.size(); k++) begin
            if (gaps) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                    step(1'b0, rnd_bit(), rand_rdy ? rnd_bit() : 1'b0);
            end
            if (k == fb.size() - 1)
                step(1'b1, fb[k], rand_rdy ? rnd_bit() : ready_last);
            else
                step(1'b1, fb[k], rand_rdy ? rnd_bit() : 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst        = 1'b1;
        sen        = 1'b0;
        sin        = 1'b1;
        dout_ready = 1'b0;
        #1;
        do_reset();

        check("reset dout",       32'(dout),       32'h0);
        check("reset dout_valid", 32'(dout_valid), 32'h0);
        check("reset busy",       32'(busy),       32'h0);
        check("reset errors",     32'({frame_err, parity_err, overrun}), 32'h0);

        // First word 4'hD.
        send_frame(4'hD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("word D dout",  32'(dout),       32'hD);
        check("word D valid", 32'(dout_valid), 32'h1);
        check("word D busy",  32'(busy),       32'h0);

        // Second word while the first is pending: overrun, old word kept.
        send_frame(4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("overrun pulse",     32'(overrun),    32'h1);
        check("overrun keep dout", 32'(dout),       32'hD);
        check("overrun keep vld",  32'(dout_valid), 32'h1);
        step(1'b0, 1'b1, 1'b0);
        check("overrun single",    32'(overrun),    32'h0);
        step(1'b0, 1'b1, 1'b1);
        check("drain valid low",   32'(dout_valid), 32'h0);

        // Bad stop bit.
        send_frame(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("frame_err pulse", 32'(frame_err),  32'h1);
        check("frame_err vld",   32'(dout_valid), 32'h0);
        check("frame_err idle",  32'(busy),       32'h0);
        step(1'b0, 1'b1, 1'b0);
        check("frame_err single", 32'(frame_err), 32'h0);

        // Reset in the middle of a frame, then a clean 4'hA.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        check("abort busy", 32'(busy), 32'h0);
        send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("after abort dout", 32'(dout),       32'hA);
        check("after abort vld",  32'(dout_valid), 32'h1);

        // Frame completes on the same cycle the pending word is taken.
        send_frame(4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("swap dout",    32'(dout),       32'h5);
        check("swap valid",   32'(dout_valid), 32'h1);
        check("swap overrun", 32'(overrun),    32'h0);
        step(1'b0, 1'b1, 1'b1);

`ifdef SHIFT_RX_PARITY_EN
        send_frame(4'hD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("parity good dout", 32'(dout),       32'hD);
        check("parity good vld",  32'(dout_valid), 32'h1);
        check("parity good perr", 32'(parity_err), 32'h0);
        step(1'b0, 1'b1, 1'b1);
        send_frame(4'hD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("parity bad perr", 32'(parity_err), 32'h1);
        check("parity bad vld",  32'(dout_valid), 32'h0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                // Partial frame aborted by reset.
                step(1'b1, 1'b0, rnd_bit());
                for (int k = 0; k < int'($urandom_range(0, W + 1)); k++)
                    step(rnd_bit(), rnd_bit(), rnd_bit());
                do_reset();
            end else if (sel < 3) begin
                // Unstructured line activity.
                for (int k = 0; k < 12; k++)
                    step(rnd_bit(), rnd_bit(), rnd_bit());
            end else begin
                send_frame(W'($urandom()), ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 9) != 0), 1'b0, 1'b1, 1'b1);
                for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                    step(rnd_bit(), 1'b1, rnd_bit());
            end
        end

        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_rx_ctrl

// File: doc/shift_rx_ctrl.md
SHIFT_RX_CTRL -- requirements
Module: shift_rx_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the number of data bits per frame (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port sen, input, 1, serial bit strobe; sin is sampled only on cycles where sen=1.
REQ-005 The block SHALL have port sin, input, 1, serial data line.
REQ-006 The block SHALL have port dout, output, WIDTH, the received parallel word.
REQ-007 The block SHALL have port dout_valid, output, 1, meaning dout holds an unconsumed word.
REQ-008 The block SHALL have port dout_ready, input, 1, the consumer accept signal.
REQ-009 The block SHALL have port busy, output, 1, which is high in any state other than IDLE.
REQ-010 The block SHALL have ports frame_err, parity_err and overrun, each output, 1, each a single-cycle error pulse.

Function
REQ-011 The block SHALL use the states IDLE, DATA, PARITY and STOP.
REQ-012 In IDLE, a sample with sen=1 and sin=0 (start bit) SHALL clear the bit counter and move to DATA; sin=1 samples SHALL be ignored.
REQ-013 In DATA, each strobed sample SHALL shift into the MSB of the shift datapath with a right shift (LSB-first framing), and the counter SHALL increment.
REQ-014 After WIDTH strobed samples, DATA SHALL go to PARITY when SHIFT_RX_PARITY_EN is defined and to STOP otherwise.
REQ-015 In PARITY, one strobed sample SHALL be taken as an even-parity bit, and the state SHALL then go to STOP.
REQ-016 In STOP, a strobed sample of 1 with no parity error SHALL complete the frame.
- The shift contents load into dout one cycle after the stop sample.
- dout_valid rises on that same cycle.
REQ-017 A stop sample of 0 SHALL discard the word, pulse frame_err on the next cycle and return to IDLE.
REQ-018 Cycles with sen=0 SHALL leave the state, counter and shift contents unchanged in every state.
REQ-019 A transfer SHALL occur when dout_valid=1 and dout_ready=1 are high in the same cycle, and dout_valid SHALL fall on the next cycle unless a new word loads.
REQ-020 dout and dout_valid SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-021 If a frame completes while dout_valid=1 and no transfer happens that cycle, the block SHALL drop the new word, keep the old dout, and pulse overrun for one cycle.
REQ-022 If a frame completes in the same cycle as a transfer, the new word SHALL load, dout_valid SHALL stay 1, and overrun SHALL NOT pulse.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL return to 0 on every entry to DATA.

Reset
REQ-024 On rst=1 the block SHALL enter IDLE and clear the counter and shift contents, aborting any frame in progress.
REQ-025 On rst=1, dout=0, dout_valid=0, busy=0, and frame_err=parity_err=overrun=0 SHALL hold on the following cycle.
REQ-026 Reset SHALL take priority over sen, sin and dout_ready.

Configuration
REQ-027 With macro SHIFT_RX_PARITY_EN defined, the block SHALL include the PARITY state.
- It checks even parity over the data bits plus the parity bit.
- On a mismatch it discards the word, pulses parity_err on the cycle after the stop sample, and still checks the stop bit.
REQ-028 Without SHIFT_RX_PARITY_EN, the PARITY state SHALL be unreachable and parity_err SHALL be tied to 0, with the port kept present.

Structure
REQ-029 Package shift_rx_pkg SHALL hold the state enum (IDLE, DATA, PARITY, STOP) and the default WIDTH constant.
REQ-030 The shift datapath SHALL be a sub-module, sipo_shift, with ports clk, rst, en, sin and q[WIDTH-1:0].
- On en it performs a right shift with sin entering the MSB.
- rst clears it synchronously.

Verification
REQ-031 (WIDTH=4, no parity) strobes 0,1,0,1,1,1 -> dout=4'hD and dout_valid=1 one cycle after the last strobe, busy=0.
REQ-032 After the first word, hold dout_ready=0 and send a second frame for 4'h3 -> overrun pulses once, dout stays 4'hD; then dout_ready=1 -> dout_valid falls next cycle.
REQ-033 Frame 0,1,1,1,1,0 (bad stop) -> frame_err pulses once, dout_valid stays 0, state returns to IDLE.
REQ-034 Assert rst after two data strobes, then send a full frame for 4'hA -> dout=4'hA with no stale bits.
REQ-035 (PARITY_EN) 4'hD with parity bit 1 and stop 1 -> valid word; the same frame with parity bit 0 -> parity_err=1, dout_valid=0.
REQ-036 Complete a frame in the same cycle as dout_ready=1 on a pending word -> new word loads, dout_valid stays 1, no overrun.
